// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register addresses, FSM
// state encodings and the STATUS word layout. CPU-side code imports the same
// package so both ends agree on addresses and encodings.
package intr_ctrl_pkg;

    // Register addresses on the 5-bit register interface
    localparam logic [4:0] INTR_PENDING = 5'd0;
    localparam logic [4:0] INTR_MASK    = 5'd1;
    localparam logic [4:0] INTR_STATUS  = 5'd2;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    // STATUS = {in_service, zeros, vector}; the vector arrives zero-extended to 8 bits
    function automatic logic [7:0] status_word(input logic in_service, input logic [7:0] vec);
        return {in_service, vec[6:0]};
    endfunction

endpackage

// File: rtl/intr_ctrl_prio_enc.sv
// Lowest-index-first priority encoder. Purely combinational: returns the index
// of the lowest set request bit and a flag saying whether any bit is set.
module prio_enc #(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = 3
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        // NOTE: every output is given a default before the loop so that no path
        // leaves it unassigned; otherwise synthesis would infer a latch.
        idx = '0;
        any = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller sitting behind the I/O controller. Rising edges on the
// interrupt lines set sticky pending bits, a software mask gates them, and a
// single request at a time is handed to the CPU via irq/ack/done. The
// lowest-index active bit wins, and the choice is made at the ack edge.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] interrupts,
    input  logic [4:0]         readaddr,
    output logic [7:0]         readdata,
    input  logic [4:0]         writeaddr,
    input  logic [7:0]         writedata,
    input  logic               write_en,
    output logic               irq,
    output logic [IDX_W-1:0]   irq_vector,
    input  logic               irq_ack,
    input  logic               irq_done
);

    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] prev;
    logic [1:0]         state;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] w1c;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [NUM_IRQ-1:0] pending_nxt;
    logic [IDX_W-1:0]   sel;
    logic               act_any;
    logic               wr_pend;
    logic               wr_mask;
    logic               take_ack;
    logic               in_service;

    // Lowest-index active request
    prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (IDX_W)
    ) u_prio_enc (
        .req (active),
        .idx (sel),
        .any (act_any)
    );

    assign rise       = interrupts & ~prev;
    assign active     = pending & mask;
    assign wr_pend    = write_en && (writeaddr == INTR_PENDING);
    assign wr_mask    = write_en && (writeaddr == INTR_MASK);
    assign take_ack   = (state == ST_REQ) && irq_ack && act_any;
    assign in_service = (state == ST_SERVICE);
    assign w1c        = wr_pend ? writedata[NUM_IRQ-1:0] : '0;
    assign ack_clr    = take_ack ? (NUM_IRQ'(1) << sel) : '0;
    // Clears are applied first and new edges OR-ed last, so a fresh edge on a
    // bit being cleared in the same cycle keeps that bit pending.
    assign pending_nxt = (pending & ~w1c & ~ack_clr) | rise;

    // Edge detector, sticky pending bits and the mask register
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples pre-edge values; this is also why an ack uses the old mask and
        // a same-cycle read returns the value from before a write.
        if (reset) begin
            prev    <= '0;
            pending <= '0;
            mask    <= '0;
        end else begin
            prev    <= interrupts;
            pending <= pending_nxt;
            if (wr_mask) begin
                mask <= writedata[NUM_IRQ-1:0];
            end
        end
    end

    // Request/service handshake FSM; irq is high exactly while in REQ
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            irq        <= 1'b0;
            irq_vector <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (act_any) begin
                        state <= ST_REQ;
                        irq   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (take_ack) begin
                        state      <= ST_SERVICE;
                        irq        <= 1'b0;
                        irq_vector <= sel;
                    end else if (!act_any) begin
                        // Software masked or cleared the request: withdraw it
                        state <= ST_IDLE;
                        irq   <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    irq <= 1'b0;
                    if (irq_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

    // Registered read mux, one cycle of latency from readaddr
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= 8'd0;
        end else begin
            case (readaddr)
                INTR_PENDING: readdata <= 8'(pending);
                INTR_MASK:    readdata <= 8'(mask);
                INTR_STATUS:  readdata <= status_word(in_service, 8'(irq_vector));
                default:      readdata <= 8'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios followed by a randomized run. A
// behavioural model tracks pending/mask and whether a request is outstanding
// or being serviced; irq, irq_vector and readdata are compared every cycle.
module tb_intr_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] interrupts;
    logic [4:0] readaddr;
    logic [7:0] readdata;
    logic [4:0] writeaddr;
    logic [7:0] writedata;
    logic       write_en;
    logic       irq;
    logic [2:0] irq_vector;
    logic       irq_ack;
    logic       irq_done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit [7:0] m_pend, m_mask, m_prev, m_rd;
    bit       m_req, m_srv;
    bit [2:0] m_vec;

    intr_ctrl #(.NUM_IRQ(8), .IDX_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .interrupts (interrupts),
        .readaddr   (readaddr),
        .readdata   (readdata),
        .writeaddr  (writeaddr),
        .writedata  (writedata),
        .write_en   (write_en),
        .irq        (irq),
        .irq_vector (irq_vector),
        .irq_ack    (irq_ack),
        .irq_done   (irq_done)
    );

    always #5 clk = ~clk;

    function automatic int lowest(input bit [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of the model, using the inputs the DUT sampled at this edge
    task automatic model_step();
        bit [7:0] act, rd, np;
        int       s;
        if (reset) begin
            m_pend = 0; m_mask = 0; m_prev = 0; m_rd = 0;
            m_req = 0;  m_srv = 0;  m_vec = 0;
            return;
        end
        act = m_pend & m_mask;
        case (readaddr)
            5'd0:    rd = m_pend;
            5'd1:    rd = m_mask;
            5'd2:    rd = {m_srv, 4'b0, m_vec};
            default: rd = 8'd0;
        endcase
        np = m_pend;
        if (write_en && writeaddr == 5'd0) np = np & ~writedata;
        if (m_req) begin
            if (irq_ack && act != 0) begin
                s = lowest(act);
                np[s] = 1'b0;
                m_vec = 3'(s);
                m_req = 0;
                m_srv = 1;
            end else if (act == 0) begin
                m_req = 0;
            end
        end else if (m_srv) begin
            if (irq_done) m_srv = 0;
        end else if (act != 0) begin
            m_req = 1;
        end
        m_pend = np | (interrupts & ~m_prev);
        if (write_en && writeaddr == 5'd1) m_mask = writedata;
        m_prev = interrupts;
        m_rd   = rd;
    endtask

    // Advance one cycle, compare against the model, release one-shot inputs
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("irq", {7'd0, irq}, {7'd0, m_req});
        chk("irq_vector", {5'd0, irq_vector}, {5'd0, m_vec});
        chk("readdata", readdata, m_rd);
        @(negedge clk);
        reset    = 1'b0;
        write_en = 1'b0;
        irq_ack  = 1'b0;
        irq_done = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        write_en  = 1'b1;
        writeaddr = a;
        writedata = d;
        tick();
    endtask

    task automatic rd(input logic [4:0] a, output logic [7:0] d);
        readaddr = a;
        tick();
        d = readdata;
    endtask

    logic [7:0] d;

    initial begin
        reset = 1'b1; interrupts = 8'h00; readaddr = 5'd0; writeaddr = 5'd0;
        writedata = 8'h00; write_en = 1'b0; irq_ack = 1'b0; irq_done = 1'b0;
        @(negedge clk);

        // Reset state
        reset = 1'b1; tick();
        chk("rst_irq", {7'd0, irq}, 8'h00);
        chk("rst_vec", {5'd0, irq_vector}, 8'h00);
        chk("rst_rd", readdata, 8'h00);

        // Line 1 already high at reset release, mask 0
        interrupts = 8'h02; reset = 1'b1; tick();
        tick();
        rd(5'd0, d);
        chk("pend_after_rst", d, 8'h02);
        chk("irq_masked", {7'd0, irq}, 8'h00);
        wr(5'd1, 8'h02);
        chk("irq_same_edge_as_mask", {7'd0, irq}, 8'h00);
        tick();
        chk("irq_after_mask", {7'd0, irq}, 8'h01);
        irq_ack = 1'b1; tick();
        irq_done = 1'b1; tick();
        interrupts = 8'h00; tick();

        // Lower line arrives between irq rise and ack
        wr(5'd1, 8'hFF);
        interrupts = 8'h02; tick();
        interrupts = 8'h01; tick();
        interrupts = 8'h00; tick();
        chk("irq_req", {7'd0, irq}, 8'h01);
        irq_ack = 1'b1; tick();
        chk("vec_low_wins", {5'd0, irq_vector}, 8'h00);
        rd(5'd0, d);
        chk("pend_after_ack", d, 8'h02);
        irq_done = 1'b1; tick();
        chk("gap_irq_low", {7'd0, irq}, 8'h00);
        tick();
        chk("irq_rerise", {7'd0, irq}, 8'h01);
        irq_ack = 1'b1; tick();
        chk("vec_second", {5'd0, irq_vector}, 8'h01);
        irq_done = 1'b1; tick();

        // Software masks the request while in REQ
        interrupts = 8'h04; tick();
        interrupts = 8'h00; tick();
        chk("irq_req2", {7'd0, irq}, 8'h01);
        wr(5'd1, 8'h00);
        tick();
        chk("irq_withdrawn", {7'd0, irq}, 8'h00);
        irq_ack = 1'b1; tick();
        rd(5'd2, d);
        chk("status_ack_ignored", d, 8'h01);

        // New edge during SERVICE waits until done
        wr(5'd0, 8'hFF);
        wr(5'd1, 8'hFF);
        interrupts = 8'h01; tick();
        interrupts = 8'h00; tick();
        irq_ack = 1'b1; tick();
        interrupts = 8'h08; tick();
        chk("svc_irq_low_a", {7'd0, irq}, 8'h00);
        interrupts = 8'h00; tick();
        chk("svc_irq_low_b", {7'd0, irq}, 8'h00);
        rd(5'd0, d);
        chk("svc_pend3", d, 8'h08);
        irq_done = 1'b1; tick();
        tick();
        chk("irq_after_done", {7'd0, irq}, 8'h01);
        irq_ack = 1'b1; tick();
        chk("vec_three", {5'd0, irq_vector}, 8'h03);
        irq_done = 1'b1; tick();

        // W1C racing a new edge on the same bit
        wr(5'd1, 8'h00);
        interrupts = 8'h02; tick();
        interrupts = 8'h00; tick();
        interrupts = 8'h02; wr(5'd0, 8'h02);
        rd(5'd0, d);
        chk("w1c_vs_edge", d, 8'h02);
        wr(5'd0, 8'hFF);
        rd(5'd0, d);
        chk("w1c_all", d, 8'h00);

        // Reset while in SERVICE
        interrupts = 8'h00; wr(5'd1, 8'hFF);
        interrupts = 8'h10; tick();
        interrupts = 8'h00; tick();
        irq_ack = 1'b1; tick();
        chk("svc_vec4", {5'd0, irq_vector}, 8'h04);
        readaddr = 5'd1; reset = 1'b1; tick();
        chk("midrst_irq", {7'd0, irq}, 8'h00);
        chk("midrst_vec", {5'd0, irq_vector}, 8'h00);
        chk("midrst_rd", readdata, 8'h00);
        rd(5'd0, d);
        chk("midrst_pend", d, 8'h00);
        rd(5'd1, d);
        chk("midrst_mask", d, 8'h00);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) interrupts = 8'($urandom);
            write_en  = ($urandom_range(0, 3) == 0);
            writeaddr = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 2));
            writedata = 8'($urandom);
            readaddr  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 2));
            irq_ack   = ($urandom_range(0, 2) == 0);
            irq_done  = ($urandom_range(0, 3) == 0);
            reset     = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
